// File: rtl/mac_tx_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing the MAC AXI-Stream TX port between two sources.
// Oversize frames are cut at MAX_PKT_LEN beats with tuser marking the cut; the rest is drained.
module mac_tx_stream_arbiter #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MAX_PKT_LEN = 1518,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk_125,
    input  logic              sys_rst,
    input  logic              arb_enable,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic              s0_tvalid,
    input  logic              s0_tlast,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic              s1_tvalid,
    input  logic              s1_tlast,
    output logic              s1_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic              m_tuser,
    input  logic              m_tready,
    output logic              busy,
    output logic              grant,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic [7:0]        abort_cnt
);

    localparam int unsigned BEAT_W = (MAX_PKT_LEN > 2) ? $clog2(MAX_PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_PKT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_grant;
    logic                r_busy;
    logic [BEAT_W-1:0]   r_beat;
    logic [CNT_W-1:0]    r_pkt_cnt0;
    logic [CNT_W-1:0]    r_pkt_cnt1;
    logic [7:0]          r_abort_cnt;

    logic [DATA_W-1:0]   w_src_tdata;
    logic                w_src_tvalid;
    logic                w_src_tlast;
    logic                w_trunc;
    logic                w_xfer;
    logic                w_src_ready;

    assign w_src_tdata  = r_grant ? s1_tdata  : s0_tdata;
    assign w_src_tvalid = r_grant ? s1_tvalid : s0_tvalid;
    assign w_src_tlast  = r_grant ? s1_tlast  : s0_tlast;
    assign w_trunc      = (r_beat == LAST_BEAT) && !w_src_tlast;
    assign w_xfer       = (r_state == ST_GRANT) && w_src_tvalid && m_tready;

    // Pass-through of the granted source; tready to the source never feeds back into m_tvalid.
    always_comb begin
        w_src_ready = 1'b0;
        m_tdata     = w_src_tdata;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        m_tuser     = 1'b0;
        case (r_state)
            ST_GRANT: begin
                w_src_ready = m_tready;
                m_tvalid    = w_src_tvalid;
                m_tlast     = w_src_tlast || w_trunc;
                m_tuser     = w_trunc;
            end
            ST_DRAIN: begin
                w_src_ready = 1'b1;
            end
            default: begin
                w_src_ready = 1'b0;
            end
        endcase
        s0_tready = w_src_ready && !r_grant;
        s1_tready = w_src_ready &&  r_grant;
    end

    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= 1'b1;
            r_busy      <= 1'b0;
            r_beat      <= '0;
            r_pkt_cnt0  <= '0;
            r_pkt_cnt1  <= '0;
            r_abort_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_beat <= '0;
                    if (arb_enable && (s0_tvalid || s1_tvalid)) begin
                        // On a tie, hand the port to whichever source did not go last.
                        r_grant <= (s0_tvalid && s1_tvalid) ? !r_grant : s1_tvalid;
                        r_state <= ST_GRANT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (w_xfer) begin
                        r_beat <= r_beat + BEAT_W'(1);
                        if (w_src_tlast) begin
                            if (r_grant) r_pkt_cnt1 <= r_pkt_cnt1 + CNT_W'(1);
                            else         r_pkt_cnt0 <= r_pkt_cnt0 + CNT_W'(1);
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else if (r_beat == LAST_BEAT) begin
                            if (r_abort_cnt != 8'hFF) r_abort_cnt <= r_abort_cnt + 8'd1;
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_src_tvalid && w_src_tlast) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign grant     = r_grant;
    assign pkt_cnt0  = r_pkt_cnt0;
    assign pkt_cnt1  = r_pkt_cnt1;
    assign abort_cnt = r_abort_cnt;

endmodule

// File: tb/tb_mac_tx_stream_arbiter.sv
// Directed bench for mac_tx_stream_arbiter: two frame-generating source models and a log of MAC-side beats.
module tb_mac_tx_stream_arbiter;

    localparam int unsigned DW   = 8;
    localparam int unsigned MAXL = 32;
    localparam int unsigned CW   = 16;

    logic          clk_125 = 1'b0;
    logic          sys_rst = 1'b1;
    logic          arb_enable = 1'b1;
    logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
    logic          s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tready;
    logic          s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tuser;
    logic          m_tready = 1'b1;
    logic          busy, grant;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;
    logic [7:0]    abort_cnt;

    mac_tx_stream_arbiter #(.DATA_W(DW), .MAX_PKT_LEN(MAXL), .CNT_W(CW)) dut (
        .clk_125(clk_125), .sys_rst(sys_rst), .arb_enable(arb_enable),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .m_tready(m_tready), .busy(busy), .grant(grant),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .abort_cnt(abort_cnt)
    );

    always #5 clk_125 = ~clk_125;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         src_len[2];
    int         src_idx[2];
    int         src_frames[2];
    logic [7:0] src_base[2];
    bit         tog_mode = 1'b0;
    bit         s1_rdy_seen, busy_seen;

    logic [7:0] oq_data[$];
    bit         oq_last[$];
    bit         oq_user[$];
    bit         oq_src[$];
    int         oq_cyc[$];

    task automatic clear_log();
        oq_data.delete(); oq_last.delete(); oq_user.delete(); oq_src.delete(); oq_cyc.delete();
        s1_rdy_seen = 1'b0;
        busy_seen   = 1'b0;
    endtask

    task automatic load(input int s, input int len, input int frames, input logic [7:0] base);
        src_len[s] = len; src_idx[s] = 0; src_frames[s] = frames; src_base[s] = base;
    endtask

    task automatic advance(input int s);
        if (src_idx[s] == src_len[s] - 1) begin
            src_idx[s] = 0;
            src_frames[s] = src_frames[s] - 1;
            src_base[s] = src_base[s] + 8'(src_len[s]);
        end else begin
            src_idx[s] = src_idx[s] + 1;
        end
    endtask

    // One clock: drive at the falling edge, observe 1 ns later, handshakes land on the next rising edge.
    task automatic cycle();
        bit v0, v1;
        @(negedge clk_125);
        cyc++;
        m_tready  = tog_mode ? ~m_tready : 1'b1;
        s0_tvalid = (src_frames[0] > 0);
        s0_tdata  = src_base[0] + 8'(src_idx[0]);
        s0_tlast  = (src_idx[0] == src_len[0] - 1);
        s1_tvalid = (src_frames[1] > 0);
        s1_tdata  = src_base[1] + 8'(src_idx[1]);
        s1_tlast  = (src_idx[1] == src_len[1] - 1);
        #1;
        if (s1_tready) s1_rdy_seen = 1'b1;
        if (busy)      busy_seen   = 1'b1;
        if (m_tvalid && m_tready) begin
            oq_data.push_back(m_tdata); oq_last.push_back(m_tlast); oq_user.push_back(m_tuser);
            oq_src.push_back(grant);    oq_cyc.push_back(cyc);
        end
        v0 = s0_tvalid && s0_tready;
        v1 = s1_tvalid && s1_tready;
        if (v0) advance(0);
        if (v1) advance(1);
    endtask

    task automatic run(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            cycle();
            if (src_frames[0] == 0 && src_frames[1] == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; arb_enable = 1'b1; tog_mode = 1'b0;
        load(0, 1, 0, 8'h00); load(1, 1, 0, 8'h80);
        repeat (3) cycle();
        sys_rst = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        load(0, 1, 0, 8'h00); load(1, 1, 0, 8'h80);
        repeat (3) cycle();
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (grant !== 1'b1)     begin errors++; $display("FAIL reset_grant: got %b expected 1", grant); end
        checks++; if (pkt_cnt0 !== 16'd0 || pkt_cnt1 !== 16'd0 || abort_cnt !== 8'd0)
            begin errors++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", pkt_cnt0, pkt_cnt1, abort_cnt); end
        checks++; if (s0_tready !== 1'b0 || s1_tready !== 1'b0)
            begin errors++; $display("FAIL reset_tready: got %b%b expected 00", s0_tready, s1_tready); end
        checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tuser !== 1'b0)
            begin errors++; $display("FAIL reset_mout: got v%b l%b u%b expected 000", m_tvalid, m_tlast, m_tuser); end
        sys_rst = 1'b0;
    endtask

    task automatic test_single_frame();
        bit ok; int start; int bad;
        do_reset();
        load(0, 30, 1, 8'h00);
        start = cyc + 1;
        run(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d frames left expected 0", src_frames[0]); end
        checks++; if (oq_data.size() !== 30) begin errors++; $display("FAIL single_count: got %0d expected 30", oq_data.size()); end
        if (oq_cyc.size() > 0) begin
            checks++; if (oq_cyc[0] !== start + 1)
                begin errors++; $display("FAIL single_latency: got cycle %0d expected %0d", oq_cyc[0], start + 1); end
        end
        bad = 0;
        foreach (oq_data[i]) if (oq_data[i] !== 8'(i) || oq_last[i] !== (i == 29) || oq_user[i] !== 1'b0 || oq_src[i] !== 1'b0) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL single_data: got %0d bad beats expected 0", bad); end
        checks++; if (s1_rdy_seen !== 1'b0) begin errors++; $display("FAIL single_s1_tready: got 1 expected 0"); end
        checks++; if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd0)
            begin errors++; $display("FAIL single_pkt_cnt: got %0d/%0d expected 1/0", pkt_cnt0, pkt_cnt1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_contention();
        bit ok; int bad; int gap_bad; logic [7:0] exp;
        do_reset();
        load(0, 10, 2, 8'h00); load(1, 10, 2, 8'h80);
        run(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cont_timeout: got %0d/%0d frames left expected 0/0", src_frames[0], src_frames[1]); end
        checks++; if (oq_data.size() !== 40) begin errors++; $display("FAIL cont_count: got %0d expected 40", oq_data.size()); end
        bad = 0; gap_bad = 0;
        if (oq_data.size() == 40) begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 10; j++) begin
                    exp = (k % 2 == 0) ? 8'(10 * (k / 2) + j) : 8'(128 + 10 * (k / 2) + j);
                    if (oq_src[k*10+j] !== ((k % 2) == 1) || oq_data[k*10+j] !== exp || oq_last[k*10+j] !== (j == 9)) bad++;
                    if (j > 0 && oq_cyc[k*10+j] - oq_cyc[k*10+j-1] != 1) gap_bad++;
                end
                if (k > 0 && oq_cyc[k*10] - oq_cyc[k*10-1] != 2) gap_bad++;
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL cont_order: got %0d bad beats expected 0", bad); end
        checks++; if (gap_bad !== 0) begin errors++; $display("FAIL cont_gap: got %0d bad gaps expected 0", gap_bad); end
        checks++; if (pkt_cnt0 !== 16'd2 || pkt_cnt1 !== 16'd2)
            begin errors++; $display("FAIL cont_pkt_cnt: got %0d/%0d expected 2/2", pkt_cnt0, pkt_cnt1); end
    endtask

    task automatic test_backpressure();
        int mism; int mirrored; int bad; bit done;
        do_reset();
        tog_mode = 1'b1;
        load(1, 20, 1, 8'h80);
        mism = 0; mirrored = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            cycle();
            if (busy && grant) begin
                mirrored++;
                if (s1_tready !== m_tready || s0_tready !== 1'b0) mism++;
            end
            if (src_frames[1] == 0) done = 1'b1;
        end
        tog_mode = 1'b0;
        repeat (3) cycle();
        checks++; if (!done) begin errors++; $display("FAIL bp_timeout: got %0d frames left expected 0", src_frames[1]); end
        checks++; if (mism !== 0 || mirrored < 20)
            begin errors++; $display("FAIL bp_mirror: got %0d mismatches over %0d cycles expected 0 over >=20", mism, mirrored); end
        bad = 0;
        foreach (oq_data[i]) if (oq_data[i] !== 8'(128 + i) || oq_last[i] !== (i == 19) || oq_src[i] !== 1'b1) bad++;
        checks++; if (oq_data.size() !== 20 || bad !== 0)
            begin errors++; $display("FAIL bp_data: got %0d beats %0d bad expected 20 beats 0 bad", oq_data.size(), bad); end
        checks++; if (pkt_cnt1 !== 16'd1) begin errors++; $display("FAIL bp_pkt_cnt: got %0d expected 1", pkt_cnt1); end
    endtask

    task automatic test_overlong();
        bit ok; int bad;
        do_reset();
        load(0, 40, 1, 8'h00);
        run(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL long_drain: got %0d frames left expected 0", src_frames[0]); end
        checks++; if (oq_data.size() !== MAXL) begin errors++; $display("FAIL long_count: got %0d expected %0d", oq_data.size(), MAXL); end
        bad = 0;
        foreach (oq_data[i]) if (oq_data[i] !== 8'(i) || oq_last[i] !== (i == MAXL - 1) || oq_user[i] !== (i == MAXL - 1)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL long_trunc_beat: got %0d bad beats expected 0", bad); end
        checks++; if (abort_cnt !== 8'd1 || pkt_cnt0 !== 16'd0)
            begin errors++; $display("FAIL long_counters: got abort %0d pkt %0d expected 1/0", abort_cnt, pkt_cnt0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL long_idle: got busy %b expected 0", busy); end
        clear_log();
        load(0, MAXL, 1, 8'h40);
        run(300, ok);
        bad = 0;
        foreach (oq_data[i]) if (oq_data[i] !== 8'(64 + i) || oq_last[i] !== (i == MAXL - 1) || oq_user[i] !== 1'b0) bad++;
        checks++; if (!ok || oq_data.size() !== MAXL || bad !== 0)
            begin errors++; $display("FAIL exact_frame: got %0d beats %0d bad expected %0d beats 0 bad", oq_data.size(), bad, MAXL); end
        checks++; if (pkt_cnt0 !== 16'd1 || abort_cnt !== 8'd1)
            begin errors++; $display("FAIL exact_counters: got pkt %0d abort %0d expected 1/1", pkt_cnt0, abort_cnt); end
    endtask

    task automatic test_enable();
        bit started; bit done; int bad;
        do_reset();
        arb_enable = 1'b0;
        load(1, 10, 2, 8'h80);
        repeat (100) cycle();
        checks++; if (oq_data.size() !== 0 || busy_seen !== 1'b0 || s1_rdy_seen !== 1'b0)
            begin errors++; $display("FAIL en_gated: got %0d beats busy %b expected 0 beats busy 0", oq_data.size(), busy_seen); end
        arb_enable = 1'b1;
        started = 1'b0;
        for (int i = 0; i < 10 && !started; i++) begin
            cycle();
            if (oq_data.size() > 0) started = 1'b1;
        end
        checks++; if (!started) begin errors++; $display("FAIL en_start: got no beat expected a beat within 10 cycles"); end
        arb_enable = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            cycle();
            if (src_frames[1] == 1) done = 1'b1;
        end
        busy_seen = 1'b0;
        repeat (50) cycle();
        bad = 0;
        foreach (oq_data[i]) if (oq_data[i] !== 8'(128 + i) || oq_last[i] !== (i == 9)) bad++;
        checks++; if (!done || oq_data.size() !== 10 || bad !== 0)
            begin errors++; $display("FAIL en_finish_frame: got %0d beats %0d bad expected 10 beats 0 bad", oq_data.size(), bad); end
        checks++; if (busy_seen !== 1'b0 || pkt_cnt1 !== 16'd1)
            begin errors++; $display("FAIL en_no_regrant: got busy %b pkt %0d expected 0/1", busy_seen, pkt_cnt1); end
        arb_enable = 1'b1;
    endtask

    task automatic test_reset_midframe();
        bit ok; bit hit;
        do_reset();
        load(1, 3, 1, 8'h80);
        run(50, ok);
        clear_log();
        load(0, 30, 1, 8'h00);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            cycle();
            if (oq_data.size() == 5) hit = 1'b1;
        end
        checks++; if (!hit || pkt_cnt1 !== 16'd1)
            begin errors++; $display("FAIL mid_setup: got %0d beats pkt1 %0d expected 5/1", oq_data.size(), pkt_cnt1); end
        sys_rst = 1'b1;
        cycle();
        checks++; if (s0_tready !== 1'b0 || s1_tready !== 1'b0 || m_tvalid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL mid_outputs: got rdy %b%b v %b busy %b expected 0000", s0_tready, s1_tready, m_tvalid, busy); end
        checks++; if (pkt_cnt0 !== 16'd0 || pkt_cnt1 !== 16'd0 || abort_cnt !== 8'd0 || grant !== 1'b1)
            begin errors++; $display("FAIL mid_state: got %0d/%0d/%0d grant %b expected 0/0/0 grant 1", pkt_cnt0, pkt_cnt1, abort_cnt, grant); end
        sys_rst = 1'b0;
        clear_log();
        load(0, 4, 1, 8'h10); load(1, 4, 1, 8'h90);
        run(100, ok);
        checks++; if (!ok || oq_data.size() !== 8)
            begin errors++; $display("FAIL mid_restart_count: got %0d beats expected 8", oq_data.size()); end
        if (oq_src.size() == 8) begin
            checks++; if (oq_src[0] !== 1'b0 || oq_src[4] !== 1'b1 || oq_data[0] !== 8'h10)
                begin errors++; $display("FAIL mid_first_tie: got src %b then %b expected 0 then 1", oq_src[0], oq_src[4]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_contention();
        test_backpressure();
        test_overlong();
        test_enable();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
